data_path: RTL and testbench
============================

DATA_PATH -- requirements
Module: data_path

Interface
REQ-001 SHALL have clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have regime, input, 2 bits: current mode from the control FSM; 0 = OFF.
REQ-004 SHALL have x_in, input, 8 bits: external operand sampled into internal register x.
REQ-005 SHALL have y_en, input, 1 bit: enables any y update.
REQ-006 SHALL have y_store_x, input, 1 bit: with y_en, y loads x.
REQ-007 SHALL have y_select_next, input, 2 bits: y next-value select; 0 hold, 1 y+1, 2 y-1, 3 zero.
REQ-008 SHALL have s_en, input, 1 bit: enables any s update.
REQ-009 SHALL have s_zero, input, 1 bit: with s_en, s loads S_INIT.
REQ-010 SHALL have s_add, input, 1 bit: with s_en and !s_zero, 1 = add s_step, 0 = subtract s_step.
REQ-011 SHALL have s_step, input, 2 bits: step magnitude 0..3.
REQ-012 SHALL have y_inc, output, 1 bit: combinational carry status back to the control FSM.
REQ-013 SHALL have y, output, 8 bits; s, output, 3 bits; s_empty, output, 1 bit (s==0); y_ovf, output, 1 bit, sticky.

Function
REQ-014 x SHALL register x_in every cycle; y_store_x loads the previous cycle's x_in (1-cycle latency).
REQ-015 When regime==0, y, s and y_ovf SHALL hold regardless of enables; x keeps sampling.
REQ-016 y update priority SHALL be: !y_en hold > y_store_x load x > y_select_next.
REQ-017 s update priority SHALL be: !s_en hold > s_zero load S_INIT (6) > s_add > subtract.
REQ-018 Add SHALL form 4-bit sum = s + s_step; if sum >= S_PERIOD (3), s <= sum - S_PERIOD, else s <= sum.
REQ-019 y_inc SHALL equal s_en & !s_zero & s_add & (s + s_step >= S_PERIOD) & (regime!=0), combinational, same cycle.
REQ-020 Subtract SHALL saturate: s <= (s >= s_step) ? s - s_step : 0.
REQ-021 y+1 at 255 and y-1 at 0 SHALL wrap (255->0, 0->255) and set y_ovf; see REQ-026.
REQ-022 y_ovf SHALL clear when s_en & s_zero in the same cycle; a simultaneous overflow SHALL win (y_ovf=1).
REQ-023 y and s updates SHALL be independent and may occur in the same cycle.

Reset
REQ-024 On rst, asynchronously: x=0, y=0, s=0, y_ovf=0; hence s_empty=1, y_inc=0.
REQ-025 rst mid-operation SHALL discard any pending update; first post-reset edge uses the reset values.

Configuration
REQ-026 With DATA_PATH_Y_SAT_EN defined, y+1 at 255 SHALL stay 255 and y-1 at 0 SHALL stay 0, still setting y_ovf; without it, wrap per REQ-021.

Structure
REQ-027 S_INIT, S_PERIOD and y_select_next encodings (Y_HOLD, Y_INC, Y_DEC, Y_CLR) SHALL live in shared package data_path_pkg, also used by the control FSM.
REQ-028 The s register, add/subtract and carry logic SHALL be sub-module step_counter; y/x/y_ovf logic stays in data_path.

Verification
REQ-029 Reset then regime=2, s_en=1, s_zero=1 -> s=6; then s_add=1, s_step=1 -> y_inc=1 that cycle, s=4 next.
REQ-030 s=2, s_add=1, s_step=1, y_en=1, y_select_next=1, y=9 -> y_inc=1, next s=0, y=10.
REQ-031 x_in=0x5A at cycle n, y_en=y_store_x=1 at cycle n+1 -> y=0x5A after n+1 edge.
REQ-032 y=255, y_select_next=1, y_en=1 -> y=0, y_ovf=1 (y=255 with DATA_PATH_Y_SAT_EN); then s_zero=1, s_en=1 -> y_ovf=0.
REQ-033 s=1, s_add=0, s_step=3 -> s=0, s_empty=1; regime=0 with all enables high -> y, s unchanged, y_inc=0.
REQ-034 rst pulsed between clock edges with s=5, y=7 -> all outputs reset immediately, no edge needed.

Source files
------------

// File: rtl/data_path_pkg.sv
// Shared constants and y_select_next encoding for the data path and its control FSM.
package data_path_pkg;

  localparam logic [2:0] S_INIT   = 3'd6;
  localparam logic [3:0] S_PERIOD = 4'd3;

  typedef enum logic [1:0] {
    Y_HOLD = 2'd0,
    Y_INC  = 2'd1,
    Y_DEC  = 2'd2,
    Y_CLR  = 2'd3
  } y_sel_e;

endpackage

// File: rtl/step_counter.sv
// Modulo-S_PERIOD step counter with saturating subtract; carry reports an add crossing the period.
module step_counter
  import data_path_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       zero,
  input  logic       add,
  input  logic [1:0] step,
  output logic [2:0] s,
  output logic       carry
);

  logic [2:0] s_q, s_d;
  logic [3:0] sum, sum_wrapped;
  logic       crossed;

  assign sum         = {1'b0, s_q} + {2'b00, step};
  assign crossed     = (sum >= S_PERIOD);
  assign sum_wrapped = sum - S_PERIOD;
  assign carry       = en & ~zero & add & crossed;
  assign s           = s_q;

  always_comb begin
    s_d = s_q;
    if (en) begin
      if (zero) begin
        s_d = S_INIT;
      end else if (add) begin
        s_d = crossed ? sum_wrapped[2:0] : sum[2:0];
      end else begin
        s_d = (s_q >= {1'b0, step}) ? s_q - {1'b0, step} : 3'd0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q <= 3'd0;
    end else begin
      s_q <= s_d;
    end
  end

endmodule

// File: rtl/data_path.sv
// Operand/y/step data path; define DATA_PATH_Y_SAT_EN to saturate y at 0/255 instead of wrapping.
module data_path
  import data_path_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] regime,
  input  logic [7:0] x_in,
  input  logic       y_en,
  input  logic       y_store_x,
  input  logic [1:0] y_select_next,
  input  logic       s_en,
  input  logic       s_zero,
  input  logic       s_add,
  input  logic [1:0] s_step,
  output logic       y_inc,
  output logic [7:0] y,
  output logic [2:0] s,
  output logic       s_empty,
  output logic       y_ovf
);

  logic [7:0] x_q, y_q, y_d;
  logic       ovf_q, ovf_d;
  logic       active, y_wrap;

  assign active = (regime != 2'd0);

  step_counter u_step_counter (
    .clk   (clk),
    .rst   (rst),
    .en    (s_en & active),
    .zero  (s_zero),
    .add   (s_add),
    .step  (s_step),
    .s     (s),
    .carry (y_inc)
  );

  always_comb begin
    y_d    = y_q;
    y_wrap = 1'b0;
    if (active && y_en) begin
      if (y_store_x) begin
        y_d = x_q;
      end else begin
        case (y_sel_e'(y_select_next))
          Y_INC: begin
            y_wrap = (y_q == 8'hFF);
`ifdef DATA_PATH_Y_SAT_EN
            y_d = y_wrap ? y_q : y_q + 8'd1;
`else
            y_d = y_q + 8'd1;
`endif
          end
          Y_DEC: begin
            y_wrap = (y_q == 8'h00);
`ifdef DATA_PATH_Y_SAT_EN
            y_d = y_wrap ? y_q : y_q - 8'd1;
`else
            y_d = y_q - 8'd1;
`endif
          end
          Y_CLR:   y_d = 8'd0;
          default: y_d = y_q;
        endcase
      end
    end
  end

  // A same-cycle overflow takes precedence over the s_zero clear.
  always_comb begin
    ovf_d = ovf_q;
    if (y_wrap) begin
      ovf_d = 1'b1;
    end else if (active && s_en && s_zero) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q   <= 8'd0;
      y_q   <= 8'd0;
      ovf_q <= 1'b0;
    end else begin
      x_q   <= x_in;
      y_q   <= y_d;
      ovf_q <= ovf_d;
    end
  end

  assign y       = y_q;
  assign y_ovf   = ovf_q;
  assign s_empty = (s == 3'd0);

endmodule

// File: tb/tb_data_path.sv
// Randomized and directed bench for data_path against an integer reference model.
module tb_data_path;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] regime;
  logic [7:0] x_in;
  logic       y_en, y_store_x;
  logic [1:0] y_select_next;
  logic       s_en, s_zero, s_add;
  logic [1:0] s_step;
  logic       y_inc;
  logic [7:0] y;
  logic [2:0] s;
  logic       s_empty, y_ovf;

  data_path dut (
    .clk           (clk),
    .rst           (rst),
    .regime        (regime),
    .x_in          (x_in),
    .y_en          (y_en),
    .y_store_x     (y_store_x),
    .y_select_next (y_select_next),
    .s_en          (s_en),
    .s_zero        (s_zero),
    .s_add         (s_add),
    .s_step        (s_step),
    .y_inc         (y_inc),
    .y             (y),
    .s             (s),
    .s_empty       (s_empty),
    .y_ovf         (y_ovf)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  // Reference state and its next value
  int mx = 0, my = 0, ms = 0, movf = 0;
  int nx, ny, ns, novf;

`ifdef DATA_PATH_Y_SAT_EN
  localparam bit Sat = 1'b1;
`else
  localparam bit Sat = 1'b0;
`endif

  task automatic check_eq(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int exp_y_inc();
    return (regime != 0 && s_en && !s_zero && s_add && (ms + s_step >= 3)) ? 1 : 0;
  endfunction

  task automatic check_all(input string tag);
    check_eq({tag, ".y"}, y, my);
    check_eq({tag, ".s"}, s, ms);
    check_eq({tag, ".s_empty"}, s_empty, (ms == 0) ? 1 : 0);
    check_eq({tag, ".y_ovf"}, y_ovf, movf);
    check_eq({tag, ".y_inc"}, y_inc, exp_y_inc());
  endtask

  task automatic model_next();
    bit act, wrapped;
    act = (regime != 0);
    wrapped = 0;
    nx = x_in;
    ny = my;
    ns = ms;
    if (act && y_en) begin
      if (y_store_x) ny = mx;
      else if (y_select_next == 1) begin
        if (my == 255) begin wrapped = 1; ny = Sat ? 255 : 0; end
        else ny = my + 1;
      end else if (y_select_next == 2) begin
        if (my == 0) begin wrapped = 1; ny = Sat ? 0 : 255; end
        else ny = my - 1;
      end else if (y_select_next == 3) ny = 0;
    end
    novf = wrapped ? 1 : (act && s_en && s_zero) ? 0 : movf;
    if (act && s_en) begin
      if (s_zero) ns = 6;
      else if (s_add) ns = (ms + s_step >= 3) ? ms + s_step - 3 : ms + s_step;
      else ns = (ms >= s_step) ? ms - s_step : 0;
    end
  endtask

  task automatic step();
    model_next();
    @(posedge clk);
    mx = nx; my = ny; ms = ns; movf = novf;
    #1;
  endtask

  task automatic drive(input int r, input int xi, input bit ye, input bit ysx, input int ysel,
                       input bit se, input bit sz, input bit sa, input int st);
    regime = 2'(r); x_in = 8'(xi); y_en = ye; y_store_x = ysx; y_select_next = 2'(ysel);
    s_en = se; s_zero = sz; s_add = sa; s_step = 2'(st);
    #1;
  endtask

  // Async pulse between edges; outputs must clear without a clock edge.
  task automatic reset_pulse(input string tag);
    rst = 1'b1;
    #1;
    mx = 0; my = 0; ms = 0; movf = 0;
    check_eq({tag, ".y"}, y, 0);
    check_eq({tag, ".s"}, s, 0);
    check_eq({tag, ".s_empty"}, s_empty, 1);
    check_eq({tag, ".y_ovf"}, y_ovf, 0);
    check_eq({tag, ".y_inc"}, y_inc, 0);
    rst = 1'b0;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #6;
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // s loads S_INIT, then an add of 1 crosses the period
    drive(2, 0, 0, 0, 0, 1, 1, 0, 0); check_all("r29a"); step();
    check_eq("r29_s_init", s, 6);
    drive(2, 0, 0, 0, 0, 1, 0, 1, 1); check_all("r29b");
    check_eq("r29_y_inc", y_inc, 1);
    step();
    check_eq("r29_s_next", s, 4);

    // s=2, y=9 then simultaneous add and y+1
    drive(1, 9, 0, 0, 0, 1, 0, 0, 2); check_all("r30a"); step();
    drive(1, 0, 1, 1, 0, 0, 0, 0, 0); check_all("r30b"); step();
    drive(1, 0, 1, 0, 1, 1, 0, 1, 1); check_all("r30c");
    check_eq("r30_y_inc", y_inc, 1);
    step();
    check_eq("r30_s", s, 0);
    check_eq("r30_y", y, 10);

    // one-cycle x latency
    drive(3, 8'h5A, 0, 0, 0, 0, 0, 0, 0); step();
    drive(3, 8'h11, 1, 1, 0, 0, 0, 0, 0); step();
    check_eq("r31_y", y, 8'h5A);

    // overflow at 255, then clear via s_zero
    drive(1, 255, 0, 0, 0, 0, 0, 0, 0); step();
    drive(1, 0, 1, 1, 0, 0, 0, 0, 0); step();
    check_eq("r32_y255", y, 255);
    drive(1, 0, 1, 0, 1, 0, 0, 0, 0); step();
    check_eq("r32_y_wrap", y, Sat ? 255 : 0);
    check_eq("r32_ovf_set", y_ovf, 1);
    drive(1, 0, 0, 0, 0, 1, 1, 0, 0); step();
    check_eq("r32_ovf_clr", y_ovf, 0);

    // s: 6 -> 3 -> 1 -> saturating subtract to 0, then regime OFF holds
    drive(1, 0, 0, 0, 0, 1, 0, 0, 3); step();
    drive(1, 0, 0, 0, 0, 1, 0, 0, 2); step();
    check_eq("r33_s1", s, 1);
    drive(1, 0, 0, 0, 0, 1, 0, 0, 3); step();
    check_eq("r33_s0", s, 0);
    check_eq("r33_empty", s_empty, 1);
    drive(0, 77, 1, 0, 1, 1, 0, 1, 3); check_all("r33_off");
    check_eq("r33_off_y_inc", y_inc, 0);
    step();
    check_all("r33_off_hold");

    // s=5, y=7 then async reset mid-cycle
    drive(1, 7, 0, 0, 0, 1, 1, 0, 0); step();
    drive(1, 0, 1, 1, 0, 1, 0, 0, 1); step();
    check_eq("r34_s5", s, 5);
    check_eq("r34_y7", y, 7);
    reset_pulse("r34_rst");
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0); step();
    check_all("r34_post");

    for (int i = 0; i < 2000; i++) begin
      drive(($urandom_range(7) == 0) ? 0 : $urandom_range(1, 3),
            ($urandom_range(3) == 0) ? (($urandom_range(1) == 0) ? 0 : 255) : $urandom_range(255),
            $urandom_range(1), ($urandom_range(3) == 0), $urandom_range(3),
            $urandom_range(1), ($urandom_range(5) == 0), $urandom_range(1), $urandom_range(3));
      check_all("rand");
      if ($urandom_range(99) == 0) begin
        reset_pulse("rand_rst");
        check_all("rand_after_rst");
      end
      step();
    end
    check_all("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
